// File: rtl/disp7_pkg.sv
// Shared constants for the 7-segment scan driver: segment bit order,
// blank pattern and the active-low hex glyph table.
package disp7_pkg;

  // Bit positions inside the 7-bit segment bus {g,f,e,d,c,b,a}.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] GLYPHS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-glyph lookup, active-low segments {g,f,e,d,c,b,a}.
module seg7_hex_decode
  import disp7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = GLYPHS[nibble_i];

endmodule

// File: rtl/disp7segs_scan.sv
// Time-multiplexed common-anode 7-segment driver with shadowed inputs,
// blanking, decimal points, leading-zero suppression and anode dead-time.
module disp7segs_scan
  import disp7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int PRESCALE    = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    lzs_i,
  input  logic                    load_i,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic [6:0]              seg_o,
  output logic                    dp_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] data_q;
  logic [NUM_DIGITS-1:0]   dp_q, blank_q;
  logic                    lzs_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dpo_q, dpo_d;

  logic                    tick;
  logic                    dead;
  logic [NUM_DIGITS-1:0]   supp;
  logic                    zero_run;
  logic [3:0]              nib;
  logic                    dp_sel;
  logic                    blank_sel;
  logic [NUM_DIGITS-1:0]   an_lit;
  logic [6:0]              glyph;

  assign tick = (presc_q == PW'(PRESCALE - 1));
  assign dead = (presc_q < PW'(DEAD_CYCLES));

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (tick) begin
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // A digit is suppressed when it and every digit above it hold zero.
  always_comb begin
    supp     = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (data_q[k*4 +: 4] == 4'h0);
      supp[k]  = lzs_q & (k > 0) & zero_run;
    end
  end

  always_comb begin
    nib       = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    an_lit    = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        nib       = data_q[k*4 +: 4];
        dp_sel    = dp_q[k];
        blank_sel = blank_q[k] | supp[k];
        an_lit[k] = 1'b0;
      end
    end
  end

  seg7_hex_decode u_dec (
    .nibble_i (nib),
    .seg_o    (glyph)
  );

  // Blank digits keep their anode so the scan cadence never changes.
  always_comb begin
    an_d  = dead ? '1 : an_lit;
    seg_d = blank_sel ? SEG_BLANK : glyph;
    dpo_d = blank_sel ? 1'b1 : ~dp_sel;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      lzs_q   <= 1'b0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
      dpo_q   <= 1'b1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dpo_q   <= dpo_d;
      if (load_i) begin
        data_q  <= data_i;
        dp_q    <= dp_i;
        blank_q <= blank_i;
        lzs_q   <= lzs_i;
      end
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = dpo_q;

endmodule

// File: tb/tb_disp7segs_scan.sv
// Directed bench for disp7segs_scan with 4 digits, prescale 4, one dead cycle.
module tb_disp7segs_scan;

  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [15:0]   data_i;
  logic [3:0]    dp_i;
  logic [3:0]    blank_i;
  logic          lzs_i;
  logic          load_i;
  logic [3:0]    an_o;
  logic [6:0]    seg_o;
  logic          dp_o;

  int            checks = 0;
  int            errors = 0;
  logic [7:0]    exp_q[$];
  logic [6:0]    scan_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

  disp7segs_scan #(
    .NUM_DIGITS  (ND),
    .PRESCALE    (4),
    .DEAD_CYCLES (1)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .dp_i    (dp_i),
    .blank_i (blank_i),
    .lzs_i   (lzs_i),
    .load_i  (load_i),
    .an_o    (an_o),
    .seg_o   (seg_o),
    .dp_o    (dp_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Inputs are driven on the falling edge; the load lands on the next rising edge.
  task automatic do_load(input logic [15:0] d, input logic [3:0] dp,
                         input logic [3:0] bl, input logic lz);
    @(negedge clk);
    data_i = d; dp_i = dp; blank_i = bl; lzs_i = lz; load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    @(negedge clk);
  endtask

  // Returns on the first lit cycle of digit d (prescaler now at 2).
  task automatic wait_digit(input int d, output bit found);
    logic [3:0] want;
    want  = ~(4'b0001 << d);
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (an_o == want) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) chk($sformatf("timeout_d%0d", d), {12'h0, an_o}, {12'h0, want});
  endtask

  task automatic check_digits(input string tag);
    bit         found;
    logic [7:0] e;
    for (int d = ND - 1; d >= 0; d--) begin
      e = exp_q.pop_front();
      wait_digit(d, found);
      if (found) chk($sformatf("%s_d%0d", tag, d), {8'h0, dp_o, seg_o}, {8'h0, e});
    end
  endtask

  initial begin
    bit found;
    rst_i = 1'b1; data_i = '0; dp_i = '0; blank_i = '0; lzs_i = 1'b0; load_i = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_an", {12'h0, an_o}, 16'h000F);
      chk("rst_seg", {9'h0, seg_o}, 16'h007F);
      chk("rst_dp", {15'h0, dp_o}, 16'h0001);
    end

    // Release reset and load 1234 in the same falling-edge slot.
    rst_i = 1'b0;
    data_i = 16'h1234; load_i = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      int ph, sl;
      @(negedge clk);
      load_i = 1'b0;
      ph = (k - 1) % 4;
      sl = ((k - 1) / 4) % 4;
      if (ph == 0) begin
        chk($sformatf("scan_dead_%0d", k), {12'h0, an_o}, 16'h000F);
      end else begin
        chk($sformatf("scan_an_%0d", k), {12'h0, an_o}, {12'h0, ~(4'b0001 << sl)});
        chk($sformatf("scan_seg_%0d", k), {9'h0, seg_o}, {9'h0, scan_seg[sl]});
      end
    end

    // Leading-zero suppression on, then off; queue holds {dp,seg} for digits 3..0.
    do_load(16'h0030, 4'b0000, 4'b0000, 1'b1);
    exp_q.push_back({1'b1, 7'h7F});
    exp_q.push_back({1'b1, 7'h7F});
    exp_q.push_back({1'b1, 7'h30});
    exp_q.push_back({1'b1, 7'h40});
    check_digits("lzs1");

    do_load(16'h0030, 4'b0000, 4'b0000, 1'b0);
    exp_q.push_back({1'b1, 7'h40});
    exp_q.push_back({1'b1, 7'h40});
    exp_q.push_back({1'b1, 7'h30});
    exp_q.push_back({1'b1, 7'h40});
    check_digits("lzs0");

    // Suppressed digit also hides its decimal point.
    do_load(16'h0005, 4'b1111, 4'b0000, 1'b1);
    exp_q.push_back({1'b1, 7'h7F});
    exp_q.push_back({1'b1, 7'h7F});
    exp_q.push_back({1'b1, 7'h7F});
    exp_q.push_back({1'b0, 7'h12});
    check_digits("lzsdp");

    do_load(16'hABCD, 4'b0110, 4'b0100, 1'b0);
    exp_q.push_back({1'b1, 7'h08});
    exp_q.push_back({1'b1, 7'h7F});
    exp_q.push_back({1'b0, 7'h27});
    exp_q.push_back({1'b1, 7'h21});
    check_digits("blkdp");

    // Load on the tick cycle of digit 1's slot.
    wait_digit(1, found);
    @(negedge clk);
    data_i = 16'hFFFF; dp_i = '0; blank_i = '0; lzs_i = 1'b0; load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    chk("tick_an_last", {12'h0, an_o}, 16'h000D);
    @(negedge clk);
    chk("tick_dead", {12'h0, an_o}, 16'h000F);
    @(negedge clk);
    chk("tick_an_next", {12'h0, an_o}, 16'h000B);
    chk("tick_seg_next", {9'h0, seg_o}, 16'h000E);

    // Reset during digit 2's slot.
    rst_i = 1'b1;
    @(negedge clk);
    chk("mid_rst_an", {12'h0, an_o}, 16'h000F);
    chk("mid_rst_seg", {9'h0, seg_o}, 16'h007F);
    chk("mid_rst_dp", {15'h0, dp_o}, 16'h0001);
    rst_i = 1'b0;
    @(negedge clk);
    chk("restart_dead", {12'h0, an_o}, 16'h000F);
    @(negedge clk);
    chk("restart_an", {12'h0, an_o}, 16'h000E);
    chk("restart_seg", {9'h0, seg_o}, 16'h0040);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
